// File: rtl/cordic_sin_engine_pkg.sv
// Shared constants, Q-format widths and FSM state encoding for the CORDIC sin/cos engine.
// Imported by the engine top and its float-to-fixed converter.
package cordic_sin_engine_pkg;

    localparam int unsigned N_ITER_DEF    = 21;
    localparam logic [31:0] K_INIT_DEF    = 32'h26DD3B6A;
    localparam logic [31:0] ANG_LIMIT_DEF = 32'h5A000000;

    // Angle is signed Q8.24 degrees, results are signed Q2.30.
    localparam int unsigned ANGLE_W    = 32;
    localparam int unsigned ANGLE_FRAC = 24;
    localparam int unsigned RES_W      = 32;
    localparam int unsigned RES_FRAC   = 30;
    localparam int unsigned IDX_W      = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFetch  = 2'd1,
        StRotate = 2'd2,
        StDone   = 2'd3
    } state_e;

endpackage

// File: rtl/f32_to_q824.sv
// Combinational IEEE-754 float32 to signed Q8.24 converter.
// Truncates small values toward zero and saturates magnitudes that do not fit.
module f32_to_q824
    import cordic_sin_engine_pkg::*;
(
    input  logic [31:0] i_f32,
    output logic [31:0] o_q824
);

    logic               w_sign;
    logic [7:0]         w_exp;
    logic [23:0]        w_mant;
    logic signed [9:0]  w_sh;
    logic signed [9:0]  w_nsh;
    logic [31:0]        w_mag;

    always_comb begin
        w_sign = i_f32[31];
        w_exp  = i_f32[30:23];
        w_mant = {1'b1, i_f32[22:0]};
        // value * 2^24 == mant * 2^(exp - 126)
        w_sh   = $signed({2'b00, w_exp}) - 10'sd126;
        w_nsh  = -w_sh;
        w_mag  = '0;
        if (w_exp == 8'd0) begin
            w_mag = '0;
        end else if (w_sh >= 10'sd0) begin
            if (w_sh > 10'sd7) begin
                w_mag = 32'h7FFFFFFF;
            end else begin
                w_mag = {8'b0, w_mant} << w_sh[2:0];
            end
        end else begin
            if (w_nsh >= 10'sd24) begin
                w_mag = '0;
            end else begin
                w_mag = {8'b0, w_mant} >> w_nsh[4:0];
            end
        end
        o_q824 = w_sign ? (~w_mag + 32'd1) : w_mag;
    end

endmodule

// File: rtl/cordic_sin_engine.sv
// CORDIC rotation sequencer: reads arctan(2^-i) degrees from an external float32 table
// and rotates (K, 0) by the requested Q8.24 angle, returning sin/cos in Q2.30.
module cordic_sin_engine
    import cordic_sin_engine_pkg::*;
#(
    parameter int unsigned N_ITER    = N_ITER_DEF,
    parameter logic [31:0] K_INIT    = K_INIT_DEF,
    parameter logic [31:0] ANG_LIMIT = ANG_LIMIT_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [31:0]      i_angle_in,
    input  logic [31:0]      i_tbl_data,
    output logic [IDX_W-1:0] o_tbl_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [31:0]      o_sin_out,
    output logic [31:0]      o_cos_out
);

    state_e             r_state;
    state_e             w_state_next;
    logic [IDX_W-1:0]   r_i;
    logic signed [31:0] r_x;
    logic signed [31:0] r_y;
    logic signed [31:0] r_z;
    logic signed [31:0] r_atan;
    logic [31:0]        r_sin;
    logic [31:0]        r_cos;
    logic               r_done;
    logic               r_err;

    logic [31:0]        w_atan_conv;
    logic signed [31:0] w_x_sh;
    logic signed [31:0] w_y_sh;
    logic signed [31:0] w_x_rot;
    logic signed [31:0] w_y_rot;
    logic signed [31:0] w_z_rot;
    logic               w_d_pos;
    logic               w_last;
    logic               w_in_range;

    f32_to_q824 u_conv (
        .i_f32  (i_tbl_data),
        .o_q824 (w_atan_conv)
    );

    always_comb begin
        w_in_range = ($signed(i_angle_in) <= $signed(ANG_LIMIT)) &&
                     ($signed(i_angle_in) >= -$signed(ANG_LIMIT));
        w_last  = (r_i == IDX_W'(N_ITER - 1));
        w_x_sh  = r_x >>> r_i;
        w_y_sh  = r_y >>> r_i;
        w_d_pos = ~r_z[31];
        // Both x and y updates use the pre-rotation values.
        if (w_d_pos) begin
            w_x_rot = r_x - w_y_sh;
            w_y_rot = r_y + w_x_sh;
            w_z_rot = r_z - r_atan;
        end else begin
            w_x_rot = r_x + w_y_sh;
            w_y_rot = r_y - w_x_sh;
            w_z_rot = r_z + r_atan;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (i_start) w_state_next = w_in_range ? StFetch : StDone;
            StFetch:  w_state_next = StRotate;
            StRotate: w_state_next = w_last ? StDone : StFetch;
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_i     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_atan  <= '0;
            r_sin   <= '0;
            r_cos   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        if (w_in_range) begin
                            r_x <= K_INIT;
                            r_y <= '0;
                            r_z <= i_angle_in;
                            r_i <= '0;
                        end else begin
                            // Error path leaves sin/cos untouched.
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end
                    end
                end
                StFetch: r_atan <= w_atan_conv;
                StRotate: begin
                    r_x <= w_x_rot;
                    r_y <= w_y_rot;
                    r_z <= w_z_rot;
                    if (w_last) begin
                        // Results registered on entry to DONE so they show with the pulse.
                        r_done <= 1'b1;
                        r_err  <= 1'b0;
                        r_sin  <= w_y_rot;
                        r_cos  <= w_x_rot;
                    end else begin
                        r_i <= r_i + IDX_W'(1);
                    end
                end
                StDone: ;
                default: ;
            endcase
        end
    end

    assign o_tbl_idx = ((r_state == StFetch) || (r_state == StRotate)) ? r_i : '0;
    assign o_busy    = (r_state != StIdle);
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_sin_out = r_sin;
    assign o_cos_out = r_cos;

endmodule

// File: tb/tb_cordic_sin_engine.sv
// Directed bench for cordic_sin_engine with a behavioural arctan table beside it,
// plus a standalone check of the float32 to Q8.24 converter.
module tb_cordic_sin_engine;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] angle_in;
    logic [31:0] tbl_data;
    logic [7:0]  tbl_idx;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] sin_out;
    logic [31:0] cos_out;

    logic        tbl_rst;
    logic [31:0] tbl_mem [0:255];

    logic [31:0] conv_in;
    logic [31:0] conv_out;

    int checks = 0;
    int errors = 0;

    cordic_sin_engine u_dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_angle_in (angle_in),
        .i_tbl_data (tbl_data),
        .o_tbl_idx  (tbl_idx),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err),
        .o_sin_out  (sin_out),
        .o_cos_out  (cos_out)
    );

    f32_to_q824 u_conv_ut (
        .i_f32  (conv_in),
        .o_q824 (conv_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] real_to_f32(input real v);
        int          e;
        real         m;
        int          frac;
        logic [31:0] fb;
        logic [7:0]  eb;
        if (v <= 0.0) return 32'h0;
        e = 0;
        m = v;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        frac = $rtoi((m - 1.0) * 8388608.0);
        fb   = frac;
        eb   = 8'(e + 127);
        return {1'b0, eb, fb[22:0]};
    endfunction

    function automatic real atan_deg(input int k);
        real p;
        p = 1.0;
        repeat (k) p = p / 2.0;
        return $atan(p) * 180.0 / 3.14159265358979323846;
    endfunction

    // Arctan table: loaded on its own reset, combinational read.
    always @(posedge clk) begin
        if (tbl_rst) begin
            for (int k = 0; k < 256; k++) begin
                tbl_mem[k] <= (k < 21) ? real_to_f32(atan_deg(k)) : 32'h0;
            end
        end
    end
    assign tbl_data = tbl_mem[tbl_idx];

    // Stimulus only: pulse start and record the first done within a bounded window.
    task automatic run_op(input logic [31:0] a, output int lat, output logic [31:0] s,
                          output logic [31:0] c, output logic e, output int ndone);
        lat      = -1;
        ndone    = 0;
        s        = 32'hx;
        c        = 32'hx;
        e        = 1'bx;
        angle_in = a;
        start    = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = n;
                    s   = sin_out;
                    c   = cos_out;
                    e   = err;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, err, tbl_idx, sin_out, cos_out} !== 75'b0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b err=%b idx=%0d sin=%h cos=%h want all 0",
                     busy, done, err, tbl_idx, sin_out, cos_out);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_converter();
        logic [31:0] vin [0:7];
        logic [31:0] vexp [0:7];
        vin[0] = 32'h42340000; vexp[0] = 32'h2D000000; // 45.0
        vin[1] = 32'h3F800000; vexp[1] = 32'h01000000; // 1.0
        vin[2] = 32'hBF800000; vexp[2] = 32'hFF000000; // -1.0
        vin[3] = 32'h00000000; vexp[3] = 32'h00000000; // 0
        vin[4] = 32'h447A0000; vexp[4] = 32'h7FFFFFFF; // 1000.0 saturates
        vin[5] = 32'hC47A0000; vexp[5] = 32'h80000001; // -1000.0 saturates
        vin[6] = 32'h37000000; vexp[6] = 32'h00000080; // 2^-17
        vin[7] = 32'h32000000; vexp[7] = 32'h00000000; // 2^-27 underflows
        for (int k = 0; k < 8; k++) begin
            conv_in = vin[k];
            #1;
            checks++;
            if (conv_out !== vexp[k]) begin
                errors++;
                $display("FAIL conv[%0d] in=%h got %h want %h", k, vin[k], conv_out, vexp[k]);
            end
        end
    endtask

    task automatic test_angle(input string name, input logic [31:0] a,
                              input logic [31:0] es, input logic [31:0] ec);
        int lat, nd, ds, dc;
        logic [31:0] s, c;
        logic e;
        run_op(a, lat, s, c, e, nd);
        ds = $signed(s - es);
        dc = $signed(c - ec);
        checks++;
        if (lat !== 43 || nd !== 1) begin
            errors++;
            $display("FAIL %s_latency got lat=%0d dones=%0d want lat=43 dones=1", name, lat, nd);
        end
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL %s_err got %b want 0", name, e);
        end
        checks++;
        if (ds > 4096 || ds < -4096) begin
            errors++;
            $display("FAIL %s_sin got %h want %h +/-1000", name, s, es);
        end
        checks++;
        if (dc > 4096 || dc < -4096) begin
            errors++;
            $display("FAIL %s_cos got %h want %h +/-1000", name, c, ec);
        end
    endtask

    // Runs right after the -90 degree case, so held outputs must still match it.
    task automatic test_range_error();
        int lat, nd, ds, dc;
        logic [31:0] s, c;
        logic e;
        run_op(32'h64000000, lat, s, c, e, nd);
        ds = $signed(s - 32'hC0000000);
        dc = $signed(c);
        checks++;
        if (lat !== 1 || nd !== 1) begin
            errors++;
            $display("FAIL err_latency got lat=%0d dones=%0d want lat=1 dones=1", lat, nd);
        end
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL err_flag got %b want 1", e);
        end
        checks++;
        if (ds > 4096 || ds < -4096 || dc > 4096 || dc < -4096) begin
            errors++;
            $display("FAIL err_hold got sin=%h cos=%h want ~c0000000 ~0", s, c);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nd, idx_bad, busy_bad;
        lat      = -1;
        nd       = 0;
        idx_bad  = 0;
        busy_bad = 0;
        angle_in = 32'h1E000000;
        start    = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            // Extra starts while busy and during the DONE cycle must be dropped.
            start = (n == 10) || (n == 43);
            if (n <= 42 && tbl_idx !== 8'((n - 1) / 2)) idx_bad++;
            if ((n <= 43) !== busy) busy_bad++;
            if (done) begin
                nd++;
                if (lat < 0) lat = n;
            end
        end
        start = 1'b0;
        checks++;
        if (idx_bad != 0) begin
            errors++;
            $display("FAIL tbl_idx_sequence got %0d bad cycles want 0", idx_bad);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL busy_window got %0d bad cycles want 0", busy_bad);
        end
        checks++;
        if (lat !== 43 || nd !== 1) begin
            errors++;
            $display("FAIL ignore_start got lat=%0d dones=%0d want lat=43 dones=1", lat, nd);
        end
    endtask

    task automatic test_mid_reset();
        int nd;
        angle_in = 32'h2D000000;
        start    = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        checks++;
        if (tbl_idx !== 8'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre got idx=%0d busy=%b want idx=5 busy=1", tbl_idx, busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({busy, done, err, tbl_idx, sin_out, cos_out} !== 75'b0) begin
            errors++;
            $display("FAIL mid_reset_clear got busy=%b done=%b err=%b idx=%0d sin=%h cos=%h want 0",
                     busy, done, err, tbl_idx, sin_out, cos_out);
        end
        nd = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL mid_reset_quiet got %0d active cycles want 0", nd);
        end
        test_angle("after_reset_m30", 32'hE2000000, 32'hE0000000, 32'h376CF5D1);
    endtask

    initial begin
        reset    = 1'b1;
        tbl_rst  = 1'b1;
        start    = 1'b0;
        angle_in = '0;
        conv_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        tbl_rst = 1'b0;
        test_reset();
        test_converter();
        test_angle("zero", 32'h00000000, 32'h00000000, 32'h40000000);
        test_angle("p30", 32'h1E000000, 32'h20000000, 32'h376CF5D1);
        test_angle("m90", 32'hA6000000, 32'hC0000000, 32'h00000000);
        test_range_error();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
